// File: rtl/fc_layer_par.sv
// fc_layer_par: parametrised fully-connected layer, y = ReLU(W*x + b).
//   M outputs, N inputs, P parallel MAC lanes, G = M/P row groups, T-bit signed data.
//   Weights and biases come from external synchronous memories (1-cycle read latency).
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   s_valid/s_ready/data_in    input stream, x[0] first
//   m_valid/m_ready/data_out   output stream, y[0] first
//   w_addr/w_data         weight memory, address g*N+j, lane k = W[g*P+k][j]
//   b_addr/b_data         bias memory, address g, lane k = b[g*P+k]
// Optional feature macro LAYER_SAT_EN: full-width products and accumulator with the
// final sum saturated to T bits before ReLU. Undefined: T-bit wrap arithmetic.
//
// state     | meaning
// S_LOAD_X  | accept N input words into the x buffer
// S_COMPUTE | stream one row group through the MAC pipeline (N+3 cycles)
// S_DRAIN   | hand the P results of the group to the output stream
module fc_layer_par #(
  parameter int M = 6,
  parameter int N = 8,
  parameter int P = 2,
  parameter int T = 16,
  localparam int G  = M / P,
  localparam int WA = (G * N > 1) ? $clog2(G * N) : 1,
  localparam int BA = (G > 1) ? $clog2(G) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic [WA-1:0]       w_addr,
  input  logic [P*T-1:0]      w_data,
  output logic [BA-1:0]       b_addr,
  input  logic [P*T-1:0]      b_data
);
  localparam int CW = $clog2(N + 3);
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
`ifdef LAYER_SAT_EN
  localparam int PW = 2 * T;
  localparam int AW = 2 * T + $clog2(N) + 1;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};
`else
  localparam int PW = T;
  localparam int AW = T;
`endif

  typedef enum logic [1:0] {S_LOAD_X, S_COMPUTE, S_DRAIN} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [BA-1:0]        r_g;
  logic [LW-1:0]        r_lane;
  logic signed [T-1:0]  r_x [N];
  logic                 r_v1, r_v2;
  logic [XW-1:0]        r_j1, r_j2;
  logic signed [PW-1:0] r_prod [P];
  logic signed [T-1:0]  r_bias [P];
  logic signed [AW-1:0] r_acc [P];
  logic signed [T-1:0]  r_obuf [P];
  logic signed [PW-1:0] w_prod [P];
  logic signed [T-1:0]  w_sum [P];
  logic signed [T-1:0]  w_res [P];
  logic                 w_last_beat, w_comp_done, w_last_lane, w_last_group;

  assign w_last_beat  = (r_state == S_LOAD_X) && s_valid && (r_cnt == CW'(N - 1));
  assign w_comp_done  = (r_state == S_COMPUTE) && (r_cnt == CW'(N + 2));
  assign w_last_lane  = (r_lane == LW'(P - 1));
  assign w_last_group = (r_g == BA'(G - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD_X;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    data_out = '0;
    w_addr   = '0;
    b_addr   = r_g;
    case (r_state)
      S_LOAD_X: begin
        s_ready = 1'b1;
        if (w_last_beat) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        // Hold the last column address while the pipeline drains.
        w_addr = WA'(int'(r_g) * N + ((r_cnt < CW'(N)) ? int'(r_cnt) : N - 1));
        if (w_comp_done) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        m_valid  = 1'b1;
        data_out = r_obuf[r_lane];
        if (m_ready && w_last_lane) w_next = w_last_group ? S_LOAD_X : S_COMPUTE;
      end
      default: w_next = S_LOAD_X;
    endcase
  end

  // r_cnt counts input beats in S_LOAD_X and pipeline cycles in S_COMPUTE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_g    <= '0;
      r_lane <= '0;
    end else begin
      case (r_state)
        S_LOAD_X: begin
          r_g <= '0;
          if (s_valid) r_cnt <= w_last_beat ? '0 : r_cnt + CW'(1);
        end
        S_COMPUTE: begin
          r_lane <= '0;
          r_cnt  <= w_comp_done ? '0 : r_cnt + CW'(1);
        end
        S_DRAIN: begin
          if (m_ready) begin
            r_lane <= w_last_lane ? '0 : r_lane + LW'(1);
            if (w_last_lane) r_g <= w_last_group ? '0 : r_g + BA'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_LOAD_X) && s_valid) r_x[r_cnt[XW-1:0]] <= data_in;
  end

  // Products sized to PW: the T-bit multiply keeps only the low bits (wrap),
  // the 2T-bit multiply of sign-extended operands is exact (saturating build).
  always_comb begin
    for (int k = 0; k < P; k++) begin
      w_prod[k] = PW'(signed'(w_data[k*T +: T])) * PW'(r_x[r_j1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= (r_state == S_COMPUTE) && (r_cnt < CW'(N));
      r_v2 <= r_v1;
    end
  end

  always_ff @(posedge clk) begin
    r_j1 <= r_cnt[XW-1:0];
    r_j2 <= r_j1;
    for (int k = 0; k < P; k++) begin
      if (r_v1) begin
        r_prod[k] <= w_prod[k];
        if (r_j1 == '0) r_bias[k] <= signed'(b_data[k*T +: T]);
      end
      // Column 0 seeds the accumulator with the bias instead of the previous sum.
      if (r_v2) r_acc[k] <= ((r_j2 == '0) ? AW'(r_bias[k]) : r_acc[k]) + AW'(r_prod[k]);
      if (w_comp_done) r_obuf[k] <= w_res[k];
    end
  end

  always_comb begin
    for (int k = 0; k < P; k++) begin
`ifdef LAYER_SAT_EN
      if (r_acc[k] > SAT_MAX)      w_sum[k] = {1'b0, {(T-1){1'b1}}};
      else if (r_acc[k] < SAT_MIN) w_sum[k] = {1'b1, {(T-1){1'b0}}};
      else                         w_sum[k] = r_acc[k][T-1:0];
`else
      w_sum[k] = r_acc[k];
`endif
      w_res[k] = w_sum[k][T-1] ? '0 : w_sum[k];
    end
  end
endmodule

// File: tb/tb_fc_layer_par.sv
`timescale 1ns/1ps
module tb_fc_layer_par;
  localparam int M = 6;
  localparam int N = 8;
  localparam int T = 16;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: y[i] = ReLU(b[i] + sum_j W[i][j]*x[j]) in the selected arithmetic.
  function automatic int ref_y(input shortint w[M][N], input shortint x[N],
                               input shortint b[M], input int i);
`ifdef LAYER_SAT_EN
    longint s;
    s = b[i];
    for (int j = 0; j < N; j++) s += longint'(w[i][j]) * longint'(x[j]);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return (s < 0) ? 0 : int'(s);
`else
    shortint s;
    s = b[i];
    for (int j = 0; j < N; j++) s = s + shortint'(int'(w[i][j]) * int'(x[j]));
    return (s < 0) ? 0 : int'(s);
`endif
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- directed instance, P=2 ----------------
  logic                rst, s_valid, s_ready, m_valid, m_ready;
  logic signed [T-1:0] data_in, data_out;
  logic [4:0]          w_addr;
  logic [1:0]          b_addr;
  logic [2*T-1:0]      w_data, b_data;
  shortint             mw[M][N];
  shortint             mb[M];
  shortint             mx[N];

  fc_layer_par #(.M(M), .N(N), .P(2), .T(T)) u_dut (
    .clk(clk), .reset(rst),
    .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      w_data[k*T +: T] <= mw[(int'(w_addr) / N) * 2 + k][int'(w_addr) % N];
      b_data[k*T +: T] <= mb[int'(b_addr) * 2 + k];
    end
  end

  task automatic fill(input shortint wv, input shortint xv, input int b0, input int bstep);
    for (int i = 0; i < M; i++) begin
      mb[i] = shortint'(b0 + bstep * i);
      for (int j = 0; j < N; j++) mw[i][j] = wv;
    end
    for (int j = 0; j < N; j++) mx[j] = xv;
  endtask

  task automatic send_x(input int count, input int gap_pct);
    int idx, budget;
    idx = 0;
    budget = 0;
    while (idx < count && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (int'($urandom_range(99)) < gap_pct) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        data_in = mx[idx];
        if (s_ready) idx++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("send_beats", idx, count);
  endtask

  task automatic recv_y(input int stall_a, input int stall_b, input int stall_len,
                        input int exp_y[M]);
    int idx, budget, stall;
    idx = 0;
    budget = 0;
    stall = 0;
    while (idx < M && budget < 1000) begin
      @(negedge clk);
      budget++;
      if ((idx == stall_a || idx == stall_b) && stall < stall_len && m_valid) begin
        m_ready = 1'b0;
        stall++;
        check_eq("hold_data", data_out, exp_y[idx]);
      end else begin
        m_ready = 1'b1;
        if (m_valid) begin
          check_eq($sformatf("y%0d", idx), data_out, exp_y[idx]);
          check_eq("s_ready_busy", s_ready, 0);
          idx++;
          stall = 0;
        end
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    check_eq("beats_out", idx, M);
    check_eq("m_valid_end", m_valid, 0);
    check_eq("s_ready_end", s_ready, 1);
  endtask

  initial begin
    int exp_y[M];
    int lat, budget;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_w_addr", w_addr, 0);
    check_eq("rst_b_addr", b_addr, 0);
    rst = 1'b0;

    // ones with bias ramp, latency
    fill(1, 1, 0, 1);
    for (int i = 0; i < M; i++) exp_y[i] = 8 + i;
    send_x(N, 0);
    check_eq("s_ready_compute", s_ready, 0);
    lat = 0;
    while (!m_valid && lat < 100) begin @(negedge clk); lat++; end
    check_eq("first_latency", lat, N + 3);
    recv_y(-1, -1, 0, exp_y);

    // negative sums clamp to zero
    fill(-1, 3, 0, 0);
    for (int i = 0; i < M; i++) exp_y[i] = 0;
    send_x(N, 30);
    recv_y(-1, -1, 0, exp_y);

    // backpressure at y[0] and y[3]
    fill(1, 1, 0, 1);
    for (int i = 0; i < M; i++) exp_y[i] = 8 + i;
    send_x(N, 20);
    recv_y(0, 3, 5, exp_y);

    // large operands: wrap vs saturate
    fill(32767, 32767, 0, 0);
`ifdef LAYER_SAT_EN
    for (int i = 0; i < M; i++) exp_y[i] = 32767;
`else
    for (int i = 0; i < M; i++) exp_y[i] = 8;
`endif
    send_x(N, 0);
    recv_y(-1, -1, 0, exp_y);

    // reset in the middle of loading discards the partial vector
    fill(1, 7, 0, 0);
    send_x(4, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_s_ready", s_ready, 1);
    check_eq("midrst_m_valid", m_valid, 0);
    fill(1, 2, 0, 0);
    for (int i = 0; i < M; i++) exp_y[i] = 16;
    send_x(N, 0);
    recv_y(-1, -1, 0, exp_y);

    budget = 0;
    while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && budget < 40000) begin
      @(negedge clk);
      budget++;
    end
    check_eq("rand_done", int'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- random instances, P = 1, 3, 6 ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int PP  = (gi == 0) ? 1 : (gi == 1) ? 3 : 6;
    localparam int GG  = M / PP;
    localparam int RWA = (GG * N > 1) ? $clog2(GG * N) : 1;
    localparam int RBA = (GG > 1) ? $clog2(GG) : 1;

    logic                rrst, sv, sr, mv, mr;
    logic signed [T-1:0] din, dout;
    logic [RWA-1:0]      wa;
    logic [RBA-1:0]      ba;
    logic [PP*T-1:0]     wd, bd;
    shortint             rw[M][N];
    shortint             rb[M];
    shortint             rx[N];
    logic                done = 1'b0;

    fc_layer_par #(.M(M), .N(N), .P(PP), .T(T)) u_dut (
      .clk(clk), .reset(rrst),
      .s_valid(sv), .s_ready(sr), .data_in(din),
      .m_valid(mv), .m_ready(mr), .data_out(dout),
      .w_addr(wa), .w_data(wd), .b_addr(ba), .b_data(bd)
    );

    always @(posedge clk) begin
      for (int k = 0; k < PP; k++) begin
        wd[k*T +: T] <= rw[(int'(wa) / N) * PP + k][int'(wa) % N];
        bd[k*T +: T] <= rb[int'(ba) * PP + k];
      end
    end

    initial begin
      int idx, budget;
      rrst = 1'b1; sv = 1'b0; mr = 1'b0; din = '0;
      repeat (3) @(negedge clk);
      rrst = 1'b0;
      for (int v = 0; v < 6; v++) begin
        for (int i = 0; i < M; i++) begin
          rb[i] = (v % 2 == 0) ? shortint'($urandom) : shortint'(int'($urandom_range(60)) - 20);
          for (int j = 0; j < N; j++)
            rw[i][j] = (v % 2 == 0) ? shortint'($urandom) : shortint'(int'($urandom_range(20)) - 8);
        end
        for (int j = 0; j < N; j++)
          rx[j] = (v % 2 == 0) ? shortint'($urandom) : shortint'(int'($urandom_range(20)) - 5);

        idx = 0;
        budget = 0;
        while (idx < N && budget < 1000) begin
          @(negedge clk);
          budget++;
          if ($urandom_range(99) < 35) sv = 1'b0;
          else begin
            sv = 1'b1;
            din = rx[idx];
            if (sr) idx++;
          end
        end
        @(negedge clk);
        sv = 1'b0;
        check_eq($sformatf("p%0d_send", PP), idx, N);

        idx = 0;
        budget = 0;
        while (idx < M && budget < 2000) begin
          @(negedge clk);
          budget++;
          mr = ($urandom_range(99) < 65);
          if (mv && mr) begin
            check_eq($sformatf("p%0d_v%0d_y%0d", PP, v, idx), dout, ref_y(rw, rx, rb, idx));
            check_eq($sformatf("p%0d_s_ready_busy", PP), sr, 0);
            idx++;
          end
          check_eq($sformatf("p%0d_b_addr_range", PP), int'(int'(ba) < GG), 1);
        end
        @(negedge clk);
        mr = 1'b0;
        check_eq($sformatf("p%0d_beats_out", PP), idx, M);
        check_eq($sformatf("p%0d_idle_ready", PP), sr, 1);
      end
      done = 1'b1;
    end
  end
endmodule
